conv_accum: RTL

CONV_ACCUM -- requirements
Module: conv_accum

---
 rtl/conv_accum.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/conv_accum.sv
`default_nettype none
// ============================================================================
// Module   : conv_accum
// Brief    : Sequences three column selects into a 3x3 MAC stage, accumulates
//            the returned partial sums, adds bias, applies ReLU + requantise.
// Revision : 1.0 - initial release
// ============================================================================
module conv_accum #(
    parameter int PIPE_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               win_valid,
    output logic               win_ready,
    output logic               busy,
    output logic [1:0]         select,
    input  logic [16:0]        partial_sum,
    input  logic signed [15:0] bias,
    input  logic [3:0]         shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               out_sat,
    output logic [15:0]        win_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [1:0]                 r_issue_idx;
    logic [PIPE_LAT-1:0]        r_tag_vld;
    logic [PIPE_LAT-1:0][1:0]   r_tag_idx;
    logic [19:0]                r_acc;
    logic signed [15:0]         r_bias;
    logic [3:0]                 r_shift;

    logic                       w_sample;
    logic [1:0]                 w_sample_idx;
    logic                       w_finish;
    logic [19:0]                w_sum;
    logic signed [20:0]         w_biased;
    logic [19:0]                w_shifted;
    logic                       w_clip;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        win_ready   = 1'b0;
        busy        = 1'b0;
        select      = 2'd0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                win_ready = 1'b1;
                if (win_valid) w_state_nxt = ISSUE;
            end
            ISSUE: begin
                busy   = 1'b1;
                select = r_issue_idx;
                if (r_issue_idx == 2'd2) w_state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (w_finish) w_state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  r_issue_idx <= 2'd0;
        else if (r_state == ISSUE) r_issue_idx <= r_issue_idx + 2'd1;
        else                       r_issue_idx <= 2'd0;
    end

    // Each issued select travels with its index; the tail marks the matching sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_vld[0] <= 1'b0;
            r_tag_idx[0] <= 2'd0;
        end else begin
            r_tag_vld[0] <= (r_state == ISSUE);
            r_tag_idx[0] <= select;
        end
    end

    generate
        for (genvar i = 1; i < PIPE_LAT; i++) begin : g_tag
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_tag_vld[i] <= 1'b0;
                    r_tag_idx[i] <= 2'd0;
                end else begin
                    r_tag_vld[i] <= r_tag_vld[i-1];
                    r_tag_idx[i] <= r_tag_idx[i-1];
                end
            end
        end
    endgenerate

    assign w_sample     = r_tag_vld[PIPE_LAT-1];
    assign w_sample_idx = r_tag_idx[PIPE_LAT-1];
    assign w_finish     = w_sample && (w_sample_idx == 2'd2) && (r_state == WAIT);

    assign w_sum     = r_acc + {3'd0, partial_sum};
    assign w_biased  = $signed({1'b0, w_sum}) + $signed({{5{r_bias[15]}}, r_bias});
    assign w_shifted = w_biased[19:0] >> r_shift;
    assign w_clip    = |w_shifted[19:8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc     <= 20'd0;
            r_bias    <= 16'sd0;
            r_shift   <= 4'd0;
            out_data  <= 8'd0;
            out_sat   <= 1'b0;
            win_count <= 16'd0;
        end else begin
            if (r_state == IDLE && win_valid) begin
                r_bias  <= bias;
                r_shift <= shift;
            end
            if (w_sample) begin
                if (w_sample_idx == 2'd0) r_acc <= {3'd0, partial_sum};
                else                      r_acc <= w_sum;
            end
            // Negative pre-activation values clamp to zero without flagging saturation.
            if (w_finish) begin
                if (w_biased[20]) begin
                    out_data <= 8'd0;
                    out_sat  <= 1'b0;
                end else begin
                    out_data <= w_clip ? 8'hFF : w_shifted[7:0];
                    out_sat  <= w_clip;
                end
            end
            if (r_state == OUT && out_ready) win_count <= win_count + 16'd1;
        end
    end

endmodule
`default_nettype wire
